// File: rtl/gray_decoder_tracker_if.sv
// Bus between a Gray-coded source and the decoder/tracker.
// The master drives the sample; the tracker drives the decoded results.
interface gray_decoder_tracker_if #(
    parameter int WIDTH = 4,
    parameter int POS_W = 16
);
    logic [WIDTH-1:0] gray_in;
    logic             in_valid;
    logic             clr_err;
    logic [WIDTH-1:0] bin_out;
    logic             out_valid;
    logic             step_up;
    logic             step_down;
    logic             hold;
    logic             err;
    logic             locked;
    logic [POS_W-1:0] position;
    logic [7:0]       err_count;

    modport master (
        output gray_in, in_valid, clr_err,
        input  bin_out, out_valid, step_up, step_down, hold, err,
               locked, position, err_count
    );

    modport slave (
        input  gray_in, in_valid, clr_err,
        output bin_out, out_valid, step_up, step_down, hold, err,
               locked, position, err_count
    );
endinterface

// File: rtl/gray_decoder_tracker.sv
// Decodes Gray samples, classifies each against the previous one and tracks
// a signed position plus a saturating error count.
//   state  | meaning
//   EMPTY  | no baseline yet; next sample becomes the baseline
//   TRACK  | last step was legal (hold / +1 / -1)
//   RESYNC | last step was an illegal jump; waiting for a legal step
module gray_decoder_tracker #(
    parameter int WIDTH = 4,
    parameter int POS_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    gray_decoder_tracker_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, TRACK, RESYNC} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] new_bin;
    logic [WIDTH-1:0] delta;
    logic             up_nxt, dn_nxt, hold_nxt, err_nxt;

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            new_bin[i] = ^(bus.gray_in >> i);
        end
    end

    assign delta = new_bin - bus.bin_out;

    always_comb begin
        state_nxt = state;
        up_nxt    = 1'b0;
        dn_nxt    = 1'b0;
        hold_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (bus.in_valid) begin
            if (state == EMPTY) begin
                state_nxt = TRACK;
            end else if (delta == '0) begin
                hold_nxt  = 1'b1;
                state_nxt = TRACK;
            end else if (delta == WIDTH'(1)) begin
                up_nxt    = 1'b1;
                state_nxt = TRACK;
            end else if (delta == '1) begin
                dn_nxt    = 1'b1;
                state_nxt = TRACK;
            end else begin
                err_nxt   = 1'b1;
                state_nxt = RESYNC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= EMPTY;
            bus.bin_out   <= '0;
            bus.out_valid <= 1'b0;
            bus.step_up   <= 1'b0;
            bus.step_down <= 1'b0;
            bus.hold      <= 1'b0;
            bus.err       <= 1'b0;
            bus.locked    <= 1'b0;
            bus.position  <= '0;
            bus.err_count <= '0;
        end else begin
            state         <= state_nxt;
            bus.out_valid <= bus.in_valid;
            bus.step_up   <= up_nxt;
            bus.step_down <= dn_nxt;
            bus.hold      <= hold_nxt;
            bus.err       <= err_nxt;
            bus.locked    <= (state_nxt == TRACK);
            if (bus.in_valid) begin
                bus.bin_out <= new_bin;
            end
            if (up_nxt) begin
                bus.position <= bus.position + POS_W'(1);
            end else if (dn_nxt) begin
                bus.position <= bus.position - POS_W'(1);
            end
            // A clear coinciding with an error still records that error.
            if (bus.clr_err) begin
                bus.err_count <= err_nxt ? 8'd1 : 8'd0;
            end else if (err_nxt && bus.err_count != 8'hFF) begin
                bus.err_count <= bus.err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_gray_decoder_tracker.sv
// Randomized and directed bench for gray_decoder_tracker with a behavioural
// reference model checked every cycle.
module tb_gray_decoder_tracker;
    localparam int WIDTH = 4;
    localparam int POS_W = 16;
    localparam int MOD   = 1 << WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_decoder_tracker_if #(.WIDTH(WIDTH), .POS_W(POS_W)) bus ();

    gray_decoder_tracker #(.WIDTH(WIDTH), .POS_W(POS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    int  m_bin, m_pos, m_cnt;
    bit  m_seen, m_locked, m_ov, m_up, m_dn, m_hold, m_err;
    int  n_up, n_dn, n_err;

    function automatic int gray_of(int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    function automatic int bin_of(int g);
        int b = 0;
        for (int s = 0; s < WIDTH; s++) b = b ^ (g >> s);
        return b % MOD;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bin = 0; m_pos = 0; m_cnt = 0; m_seen = 0; m_locked = 0;
        m_ov = 0; m_up = 0; m_dn = 0; m_hold = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input int g, input bit c, input bit r);
        int nb, d;
        if (r) begin
            model_reset();
            return;
        end
        m_ov = v; m_up = 0; m_dn = 0; m_hold = 0; m_err = 0;
        if (c) m_cnt = 0;
        if (v) begin
            nb = bin_of(g);
            if (!m_seen) begin
                m_seen = 1; m_locked = 1;
            end else begin
                d = (nb - m_bin + MOD) % MOD;
                if (d == 0) begin m_hold = 1; m_locked = 1; end
                else if (d == 1) begin m_up = 1; m_pos++; m_locked = 1; end
                else if (d == MOD - 1) begin m_dn = 1; m_pos--; m_locked = 1; end
                else begin
                    m_err = 1; m_locked = 0;
                    m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
                end
            end
            m_bin = nb;
        end
    endtask

    // Drives one cycle of stimulus, advances the model, then compares every output.
    task automatic cycle(input bit v, input int g, input bit c, input bit r);
        logic [POS_W-1:0] pexp;
        bus.in_valid = v;
        bus.gray_in  = WIDTH'(g);
        bus.clr_err  = c;
        rst          = r;
        @(posedge clk);
        model_step(v, g, c, r);
        @(negedge clk);
        pexp = POS_W'(m_pos);
        chk("bin_out",   32'(bus.bin_out),   32'(m_bin));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("flags", {28'd0, bus.step_up, bus.step_down, bus.hold, bus.err},
                     {28'd0, m_up, m_dn, m_hold, m_err});
        chk("locked",    32'(bus.locked),    32'(m_locked));
        chk("position",  32'(bus.position),  32'(pexp));
        chk("err_count", 32'(bus.err_count), 32'(m_cnt));
        if (bus.step_up)   n_up++;
        if (bus.step_down) n_dn++;
        if (bus.err)       n_err++;
    endtask

    initial begin
        int b, r, g;
        model_reset();
        bus.in_valid = 0; bus.gray_in = '0; bus.clr_err = 0;
        @(negedge clk);

        // reset state
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("reset_pos",    32'(bus.position),  32'd0);
        chk("reset_locked", 32'(bus.locked),    32'd0);

        // baseline 0000
        cycle(1, 0, 0, 0);
        chk("base_valid",  32'(bus.out_valid), 32'd1);
        chk("base_flags",  {28'd0, bus.step_up, bus.step_down, bus.hold, bus.err}, 32'd0);
        chk("base_locked", 32'(bus.locked),    32'd1);

        // sweep up through wrap
        n_up = 0; n_err = 0;
        for (int k = 1; k <= 16; k++) cycle(1, gray_of(k % MOD), 0, 0);
        chk("sweep_ups", 32'(n_up),         32'd16);
        chk("sweep_pos", 32'(bus.position), 32'd16);
        chk("sweep_err", 32'(n_err),        32'd0);

        // step down across wrap
        cycle(0, 0, 0, 1);
        n_dn = 0;
        cycle(1, 'b0000, 0, 0);
        cycle(1, 'b1000, 0, 0);
        cycle(1, 'b1001, 0, 0);
        chk("down_cnt", 32'(n_dn),         32'd2);
        chk("down_pos", 32'(bus.position), 32'h0000FFFE);

        // illegal jump then recover
        cycle(0, 0, 0, 1);
        cycle(1, 'b0010, 0, 0);
        cycle(1, 'b0111, 0, 0);
        chk("jump_err",    32'(bus.err),       32'd1);
        chk("jump_locked", 32'(bus.locked),    32'd0);
        chk("jump_bin",    32'(bus.bin_out),   32'd5);
        chk("jump_pos",    32'(bus.position),  32'd0);
        chk("jump_cnt",    32'(bus.err_count), 32'd1);
        cycle(1, 'b0110, 0, 0);
        chk("recover_dn",     32'(bus.step_down), 32'd1);
        chk("recover_locked", 32'(bus.locked),    32'd1);

        // saturating error counter (bin alternates far from previous)
        for (int k = 0; k < 260; k++) cycle(1, gray_of((k % 2 == 0) ? 12 : 4), 0, 0);
        chk("sat_cnt", 32'(bus.err_count), 32'd255);
        cycle(0, 0, 1, 0);
        chk("clr_alone", 32'(bus.err_count), 32'd0);
        cycle(1, gray_of(12), 0, 0);
        cycle(1, gray_of(4), 1, 0);
        chk("clr_with_err", 32'(bus.err_count), 32'd1);

        // reset mid-stream wins over a valid sample
        cycle(0, 0, 0, 1);
        for (int k = 0; k <= 5; k++) cycle(1, gray_of(k), 0, 0);
        chk("mid_pos", 32'(bus.position), 32'd5);
        cycle(1, gray_of(6), 0, 1);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_pos",   32'(bus.position),  32'd0);
        chk("mid_rst_bin",   32'(bus.bin_out),   32'd0);
        cycle(1, gray_of(9), 0, 0);
        chk("rebase_bin",   32'(bus.bin_out), 32'd9);
        chk("rebase_flags", {28'd0, bus.step_up, bus.step_down, bus.hold, bus.err}, 32'd0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 2)      b = m_bin;
            else if (r <= 5) b = (m_bin + 1) % MOD;
            else if (r <= 8) b = (m_bin + MOD - 1) % MOD;
            else             b = int'($urandom_range(0, MOD - 1));
            g = gray_of(b);
            cycle($urandom_range(0, 3) != 0, g, $urandom_range(0, 40) == 0,
                  $urandom_range(0, 200) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
